// File: rtl/rv32i_tb.sv
// Single-cycle RV32I subset core (R/I ALU ops, LW, SW) with word-addressed program
// and data memories that a bench can preload through hierarchical references.

module rv32i_mem_prog #(
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic [AW-1:0] addr,
    output logic [31:0]   rdata
);
    logic [31:0] progArray [0:DEPTH-1];

    // Loader port gives the array a driver; the core ties it off.
    always_ff @(posedge clk) begin
        if (load_we) progArray[load_addr] <= load_data;
    end

    assign rdata = progArray[addr];
endmodule

module rv32i_mem_data #(
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] dataArray [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) dataArray[addr] <= wdata;
    end

    assign rdata = dataArray[addr];
endmodule

module rv32i_core #(
    parameter int          PROG_DEPTH = 256,
    parameter int          DATA_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        rd_we,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_wdata
);
    localparam int PAW = $clog2(PROG_DEPTH);
    localparam int DAW = $clog2(DATA_DEPTH);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    logic [31:0] regs [0:31];
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] alu_b;
    logic [4:0]  shamt;
    logic [31:0] alu_y;
    logic        alu_ok;
    logic        is_r;
    logic        is_i;
    logic        is_lw;
    logic        is_sw;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        addr_unused;

    assign opcode = instr[6:0];
    assign rd_addr = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1 = instr[19:15];
    assign rs2 = instr[24:20];
    assign funct7 = instr[31:25];
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};

    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

    assign is_r  = (opcode == OP_R);
    assign is_i  = (opcode == OP_I);
    assign is_lw = (opcode == OP_LOAD) && (funct3 == 3'b010);
    assign is_sw = (opcode == OP_STORE) && (funct3 == 3'b010);

    // imm_i[4:0] equals instr[24:20], so one shamt source covers both forms.
    assign alu_b = is_r ? rs2_val : imm_i;
    assign shamt = alu_b[4:0];

    always_comb begin
        alu_ok = 1'b0;
        if (is_r) begin
            alu_ok = (funct7 == 7'h00) ||
                     ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        end else if (is_i) begin
            case (funct3)
                3'b001:  alu_ok = (funct7 == 7'h00);
                3'b101:  alu_ok = (funct7 == 7'h00) || (funct7 == 7'h20);
                default: alu_ok = 1'b1;
            endcase
        end
    end

    always_comb begin
        alu_y = 32'd0;
        case (funct3)
            3'b000:  alu_y = (is_r && funct7[5]) ? rs1_val - alu_b : rs1_val + alu_b;
            3'b001:  alu_y = rs1_val << shamt;
            3'b010:  alu_y = {31'd0, $signed(rs1_val) < $signed(alu_b)};
            3'b011:  alu_y = {31'd0, rs1_val < alu_b};
            3'b100:  alu_y = rs1_val ^ alu_b;
            3'b101:  alu_y = funct7[5] ? 32'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
            3'b110:  alu_y = rs1_val | alu_b;
            default: alu_y = rs1_val & alu_b;
        endcase
    end

    assign mem_addr = rs1_val + (is_sw ? imm_s : imm_i);
    assign rd_we    = rst_n && (alu_ok || is_lw) && (rd_addr != 5'd0);
    assign rd_wdata = is_lw ? mem_rdata : alu_y;
    assign addr_unused = ^{pc[31:PAW+2], pc[1:0], mem_addr[31:DAW+2], mem_addr[1:0]};

    rv32i_mem_prog #(.DEPTH(PROG_DEPTH)) mem_prog_inst (
        .clk       (clk),
        .load_we   (1'b0),
        .load_addr ('0),
        .load_data (32'd0),
        .addr      (pc[PAW+1:2]),
        .rdata     (instr)
    );

    rv32i_mem_data #(.DEPTH(DATA_DEPTH)) mem_data_inst (
        .clk   (clk),
        .we    (rst_n && is_sw),
        .addr  (mem_addr[DAW+1:2]),
        .wdata (rs2_val),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= RESET_PC;
        else        pc <= pc + 32'd4;
    end

    // x0 is cleared here and never written, so it stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (rd_we) begin
            regs[rd_addr] <= rd_wdata;
        end
    end
endmodule

module rv32i_tb #(
    parameter int          PROG_DEPTH = 256,
    parameter int          DATA_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        rd_we,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_wdata
);
    rv32i_core #(
        .PROG_DEPTH (PROG_DEPTH),
        .DATA_DEPTH (DATA_DEPTH),
        .RESET_PC   (RESET_PC)
    ) top_inst (
        .clk      (clk),
        .rst_n    (rst_n),
        .pc       (pc),
        .instr    (instr),
        .rd_we    (rd_we),
        .rd_addr  (rd_addr),
        .rd_wdata (rd_wdata)
    );
endmodule

// File: tb/tb_rv32i_tb.sv
// Bench for rv32i_tb: directed programs plus random programs, each cycle compared
// against an instruction-level reference model of the architectural state.

module tb_rv32i_tb;
    localparam int          PD  = 256;
    localparam int          DD  = 256;
    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam int          EW  = 102;
    localparam logic [6:0]  OPR = 7'b0110011;
    localparam logic [6:0]  OPI = 7'b0010011;
    localparam logic [6:0]  OPL = 7'b0000011;
    localparam logic [31:0] NOP_W = 32'h0000_0013;

    typedef enum {
        I_NOP, I_ADD, I_SUB, I_SLL, I_SLT, I_SLTU, I_XOR, I_SRL, I_SRA, I_OR, I_AND,
        I_ADDI, I_SLTI, I_SLTIU, I_XORI, I_ORI, I_ANDI, I_SLLI, I_SRLI, I_SRAI, I_LW, I_SW
    } mnem_e;

    // clock / reset
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;

    always #5 clk = ~clk;

    rv32i_tb #(.PROG_DEPTH(PD), .DATA_DEPTH(DD), .RESET_PC(RPC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pc       (pc),
        .instr    (instr),
        .rd_we    (rd_we),
        .rd_addr  (rd_addr),
        .rd_wdata (rd_wdata)
    );

    // scoreboard state
    int            n_tests = 0;
    int            n_fail = 0;
    logic [EW-1:0] exp_q[$];
    logic [31:0]   prog_q[$];
    logic [31:0]   m_prog [0:PD-1];
    logic [31:0]   m_data [0:DD-1];
    logic [31:0]   m_regs [0:31];
    logic [31:0]   m_pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OPR};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic mnem_e decode(input logic [31:0] w);
        mnem_e r_tab [8] = '{I_ADD, I_SLL, I_SLT, I_SLTU, I_XOR, I_SRL, I_OR, I_AND};
        mnem_e i_tab [8] = '{I_ADDI, I_SLLI, I_SLTI, I_SLTIU, I_XORI, I_SRLI, I_ORI, I_ANDI};
        logic [6:0] f7;
        logic [2:0] f3;
        f7 = w[31:25];
        f3 = w[14:12];
        if (w[6:0] == OPR) begin
            if (f7 == 7'h00) return r_tab[f3];
            if (f7 == 7'h20 && f3 == 3'd0) return I_SUB;
            if (f7 == 7'h20 && f3 == 3'd5) return I_SRA;
            return I_NOP;
        end
        if (w[6:0] == OPI) begin
            if (f3 == 3'd1) return (f7 == 7'h00) ? I_SLLI : I_NOP;
            if (f3 == 3'd5) return (f7 == 7'h00) ? I_SRLI : (f7 == 7'h20) ? I_SRAI : I_NOP;
            return i_tab[f3];
        end
        if (w[6:0] == OPL && f3 == 3'd2) return I_LW;
        if (w[6:0] == 7'b0100011 && f3 == 3'd2) return I_SW;
        return I_NOP;
    endfunction

    function automatic logic [31:0] sra(input logic [31:0] a, input logic [4:0] sh);
        return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
    endfunction

    // reference model: execute one instruction, queue what the DUT must show this cycle
    task automatic model_step();
        logic [31:0] w, a, b, imm, simm, res, addr;
        logic [4:0]  rd;
        logic        we;
        mnem_e       m;
        w    = m_prog[(m_pc / 4) % PD];
        m    = decode(w);
        rd   = w[11:7];
        a    = m_regs[w[19:15]];
        b    = m_regs[w[24:20]];
        imm  = {{20{w[31]}}, w[31:20]};
        simm = {{20{w[31]}}, w[31:25], w[11:7]};
        we   = 1'b1;
        res  = 32'd0;
        case (m)
            I_ADD:   res = a + b;
            I_SUB:   res = a - b;
            I_AND:   res = a & b;
            I_OR:    res = a | b;
            I_XOR:   res = a ^ b;
            I_SLL:   res = a << b[4:0];
            I_SRL:   res = a >> b[4:0];
            I_SRA:   res = sra(a, b[4:0]);
            I_SLT:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            I_SLTU:  res = (a < b) ? 32'd1 : 32'd0;
            I_ADDI:  res = a + imm;
            I_ANDI:  res = a & imm;
            I_ORI:   res = a | imm;
            I_XORI:  res = a ^ imm;
            I_SLTI:  res = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
            I_SLTIU: res = (a < imm) ? 32'd1 : 32'd0;
            I_SLLI:  res = a << w[24:20];
            I_SRLI:  res = a >> w[24:20];
            I_SRAI:  res = sra(a, w[24:20]);
            I_LW: begin
                addr = a + imm;
                res  = m_data[(addr / 4) % DD];
            end
            default: we = 1'b0;
        endcase
        if (rd == 5'd0) we = 1'b0;
        exp_q.push_back({m_pc, w, we, rd, res});
        if (we) m_regs[rd] = res;
        if (m == I_SW) begin
            addr = a + simm;
            m_data[(addr / 4) % DD] = b;
        end
        m_pc = m_pc + 32'd4;
    endtask

    // driver tasks
    task automatic load_mems();
        for (int i = 0; i < PD; i++) begin
            m_prog[i] = (i < prog_q.size()) ? prog_q[i] : NOP_W;
            dut.top_inst.mem_prog_inst.progArray[i] <= m_prog[i];
        end
        for (int i = 0; i < DD; i++) dut.top_inst.mem_data_inst.dataArray[i] <= m_data[i];
    endtask

    task automatic model_reset();
        m_pc = RPC;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    endtask

    // leaves the bench at a falling edge with rst_n just released
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_pc", pc, RPC);
        check("rst_rd_we", {31'd0, rd_we}, 32'd0);
        load_mems();
        model_reset();
        @(posedge clk);
        #1;
        check("rst_hold_pc", pc, RPC);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_cycles(input int n);
        logic [EW-1:0] e;
        for (int k = 0; k < n; k++) begin
            #1;
            model_step();
            e = exp_q.pop_front();
            check("pc", pc, e[101:70]);
            check("instr", instr, e[69:38]);
            check("rd_we", {31'd0, rd_we}, {31'd0, e[37]});
            check("rd_addr", {27'd0, rd_addr}, {27'd0, e[36:32]});
            if (e[37]) check("rd_wdata", rd_wdata, e[31:0]);
            @(negedge clk);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 1; i < 32; i++) check(tag, dut.top_inst.regs[i], m_regs[i]);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2, sh;
        logic [2:0]  f3;
        logic [11:0] imm;
        int          kind;
        rd   = 5'($urandom_range(0, 7));
        rs1  = 5'($urandom_range(0, 7));
        rs2  = 5'($urandom_range(0, 7));
        sh   = 5'($urandom_range(0, 31));
        f3   = 3'($urandom_range(0, 7));
        imm  = 12'($urandom);
        kind = $urandom_range(0, 9);
        case (kind)
            0, 1, 2: return enc_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1)
                                  ? 7'h20 : 7'h00, rs2, rs1, f3, rd);
            3, 4, 5: begin
                if (f3 == 3'd1) imm = {7'h00, sh};
                if (f3 == 3'd5) imm = {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, sh};
                return enc_i(imm, rs1, f3, rd, OPI);
            end
            6:       return enc_i(imm, rs1, 3'b010, rd, OPL);
            7:       return enc_s(imm, rs2, rs1);
            8:       return {imm, rs1, f3, rd, 7'b0110111};
            default: return enc_r(7'h01, rs2, rs1, f3, rd);
        endcase
    endfunction

    initial begin
        for (int i = 0; i < DD; i++) m_data[i] = $urandom;

        // ADD after two ADDIs
        prog_q = '{enc_i(12'd5, 5'd0, 3'd0, 5'd1, OPI), enc_i(12'd7, 5'd0, 3'd0, 5'd2, OPI),
                   enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3)};
        do_reset();
        run_cycles(3);
        check("add_pc", pc, 32'd12);
        check("add_x3", dut.top_inst.regs[3], 32'd12);

        // AND / ANDI with all-ones immediate
        prog_q = '{enc_i(12'h0F0, 5'd0, 3'd0, 5'd1, OPI), enc_i(12'h0FF, 5'd0, 3'd0, 5'd2, OPI),
                   enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd3), enc_i(12'hFFF, 5'd1, 3'd7, 5'd4, OPI)};
        do_reset();
        run_cycles(4);
        check("and_x3", dut.top_inst.regs[3], 32'h0F0);
        check("andi_x4", dut.top_inst.regs[4], 32'h0F0);

        // SLLI by 31 and by 0
        prog_q = '{enc_i(12'd1, 5'd0, 3'd0, 5'd1, OPI), enc_i(12'd31, 5'd1, 3'd1, 5'd5, OPI),
                   enc_i(12'd0, 5'd1, 3'd1, 5'd6, OPI)};
        do_reset();
        run_cycles(3);
        check("slli31_x5", dut.top_inst.regs[5], 32'h8000_0000);
        check("slli0_x6", dut.top_inst.regs[6], 32'h1);

        // signed vs unsigned compares
        prog_q = '{enc_i(12'hFFF, 5'd0, 3'd0, 5'd1, OPI), enc_i(12'd0, 5'd1, 3'd2, 5'd6, OPI),
                   enc_i(12'd1, 5'd1, 3'd3, 5'd7, OPI), enc_i(12'hFFF, 5'd0, 3'd3, 5'd8, OPI)};
        do_reset();
        run_cycles(4);
        check("slti_x6", dut.top_inst.regs[6], 32'd1);
        check("sltiu_x7", dut.top_inst.regs[7], 32'd0);
        check("sltiu_x8", dut.top_inst.regs[8], 32'd1);

        // LW / SW through preloaded data memory
        m_data[1] = 32'hDEAD_BEEF;
        prog_q = '{enc_i(12'd4, 5'd0, 3'd2, 5'd9, OPL), enc_s(12'd8, 5'd9, 5'd0)};
        do_reset();
        run_cycles(2);
        check("lw_x9", dut.top_inst.regs[9], 32'hDEAD_BEEF);
        check("sw_mem2", dut.top_inst.mem_data_inst.dataArray[2], 32'hDEAD_BEEF);

        // reset asserted mid-program, then rerun
        prog_q = '{enc_i(12'd5, 5'd0, 3'd0, 5'd1, OPI), enc_i(12'd7, 5'd0, 3'd0, 5'd2, OPI),
                   enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), enc_s(12'd12, 5'd3, 5'd0),
                   enc_i(12'd1, 5'd3, 3'd0, 5'd10, OPI)};
        do_reset();
        run_cycles(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_pc", pc, RPC);
        model_reset();
        check_regs("mid_rst_reg");
        for (int i = 0; i < DD; i++)
            check("mid_rst_mem", dut.top_inst.mem_data_inst.dataArray[i], m_data[i]);
        check("mid_rst_prog", dut.top_inst.mem_prog_inst.progArray[2], m_prog[2]);
        @(posedge clk);
        #1;
        check("mid_rst_hold_pc", pc, RPC);
        check("mid_rst_rd_we", {31'd0, rd_we}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_cycles(5);
        check("rerun_x10", dut.top_inst.regs[10], 32'd13);
        check("rerun_mem3", dut.top_inst.mem_data_inst.dataArray[3], 32'd12);

        // random programs
        for (int p = 0; p < 4; p++) begin
            prog_q.delete();
            for (int i = 0; i < 64; i++) prog_q.push_back(rand_instr());
            for (int i = 0; i < DD; i++) m_data[i] = $urandom;
            do_reset();
            run_cycles(64);
            check_regs("rand_reg");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
